// File: rtl/agnus_blitter_word_aligner.sv
// Blitter source-path word aligner: masks, merges and shifts source words over an hsize x vsize blit.
// Optional all-zero result flag is built when BLITTER_ZERO_FLAG_EN is defined.
module agnus_blitter_word_aligner #(
   parameter int HBITS = 6,
   parameter int VBITS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             desc,
   input  logic [3:0]       shift,
   input  logic [HBITS-1:0] hsize,
   input  logic [VBITS-1:0] vsize,
   input  logic [15:0]      fwm,
   input  logic [15:0]      lwm,
   input  logic [15:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_first,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state;
   logic             desc_q;
   logic [3:0]       shift_q;
   logic [15:0]      fwm_q;
   logic [15:0]      lwm_q;
   logic [HBITS-1:0] hsize_q;
   logic [HBITS-1:0] wcnt;
   logic [VBITS-1:0] rcnt;
   logic [15:0]      old;

   logic             accept;
   logic             consume;
   logic             row_first;
   logic             row_last;
   logic             blit_last;
   logic [15:0]      mask;
   logic [15:0]      new_word;
   logic [15:0]      old_eff;
   logic [31:0]      asc_cat;
   logic [31:0]      desc_cat;
   logic [15:0]      aligned;

   // Counters load the raw size, so a size of 0 wraps through the full range before reaching 1.
   assign row_first = (wcnt == hsize_q);
   assign row_last  = (wcnt == HBITS'(1));
   assign blit_last = row_last && (rcnt == VBITS'(1));

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;

   // NOTE: every variable driven here gets a default first, so no latch can be inferred.
   always_comb begin
      mask = 16'hFFFF;
      if (row_first && row_last) mask = fwm_q & lwm_q;
      else if (row_first)        mask = fwm_q;
      else if (row_last)         mask = lwm_q;
   end

   assign new_word = in_data & mask;
   assign old_eff  = row_first ? 16'h0000 : old;

   // Shifting the 32-bit pair keeps shift 0 free of any 16-bit-shift artefact from the old word.
   assign asc_cat  = {old_eff, new_word} >> shift_q;
   assign desc_cat = {new_word, old_eff} << shift_q;
   assign aligned  = desc_q ? desc_cat[31:16] : asc_cat[15:0];

`ifdef BLITTER_ZERO_FLAG_EN
   logic zero_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zero_q <= 1'b0;
      end else if (state == IDLE && start) begin
         zero_q <= 1'b1;
      end else if (consume && out_data != 16'h0000) begin
         zero_q <= 1'b0;
      end
   end

   assign zero = zero_q;
`else
   assign zero = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         desc_q    <= 1'b0;
         shift_q   <= 4'd0;
         fwm_q     <= 16'h0000;
         lwm_q     <= 16'h0000;
         hsize_q   <= '0;
         wcnt      <= '0;
         rcnt      <= '0;
         old       <= 16'h0000;
         out_data  <= 16'h0000;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (consume) out_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  desc_q  <= desc;
                  shift_q <= shift;
                  fwm_q   <= fwm;
                  lwm_q   <= lwm;
                  hsize_q <= hsize;
                  wcnt    <= hsize;
                  rcnt    <= vsize;
                  old     <= 16'h0000;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end

            RUN: begin
               if (accept) begin
                  out_data  <= aligned;
                  out_valid <= 1'b1;
                  out_first <= row_first;
                  out_last  <= row_last;
                  old       <= new_word;
                  if (row_last) begin
                     wcnt <= hsize_q;
                     rcnt <= rcnt - VBITS'(1);
                     if (blit_last) state <= DRAIN;
                  end else begin
                     wcnt <= wcnt - HBITS'(1);
                  end
               end
            end

            DRAIN: begin
               if (consume) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_agnus_blitter_word_aligner.sv
// Directed bench for agnus_blitter_word_aligner: vector table of small blits plus
// backpressure, long random-ready, mid-blit reset and ignored-start sequences.
module tb_agnus_blitter_word_aligner;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        desc = 1'b0;
   logic [3:0]  shift = 4'd0;
   logic [5:0]  hsize = 6'd0;
   logic [9:0]  vsize = 10'd0;
   logic [15:0] fwm = 16'h0000;
   logic [15:0] lwm = 16'h0000;
   logic [15:0] in_data = 16'h0000;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_first;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        zero;

   agnus_blitter_word_aligner dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .desc      (desc),
      .shift     (shift),
      .hsize     (hsize),
      .vsize     (vsize),
      .fwm       (fwm),
      .lwm       (lwm),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_first (out_first),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        d;
      logic [3:0]  sh;
      logic [5:0]  hs;
      logic [9:0]  vs;
      logic [15:0] fm;
      logic [15:0] lm;
      int          n;
      logic [15:0] din[4];
      logic [15:0] dout[4];
      logic [3:0]  fst;
      logic [3:0]  lst;
      logic        zr;
   } vec_t;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   logic [15:0] src[$];
   logic [15:0] got_data[$];
   bit          got_first[$];
   bit          got_last[$];

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // mode 0: sink always ready; 1: random ready; 2: five-cycle stall after the first output.
   task automatic run_blit(input string tag, input logic d, input logic [3:0] sh,
                           input logic [5:0] hs, input logic [9:0] vs,
                           input logic [15:0] fm, input logic [15:0] lm,
                           input int mode, input bit poke);
      int          idx = 0;
      int          cyc = 0;
      int          n = src.size();
      int          stall_at = -1;
      bit          acc;
      logic [15:0] held = 16'h0000;
      got_data.delete();
      got_first.delete();
      got_last.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      desc = d; shift = sh; hsize = hs; vsize = vs; fwm = fm; lwm = lm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, " busy_after_start"}, busy, 1'b1);
      // Scramble configuration: it must only be sampled on start.
      desc = ~d; shift = sh + 4'd3; hsize = hs + 6'd1; vsize = vs + 10'd1; fwm = ~fm; lwm = ~lm;
      in_valid = 1'b1;
      in_data  = src[0];
      while (!(got_data.size() == n && !busy) && cyc < 4000) begin
         case (mode)
            1:       out_ready = ($urandom_range(0, 2) != 0);
            2:       out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
            default: out_ready = 1'b1;
         endcase
         if (poke) start = (cyc == 3);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_first.push_back(out_first);
            got_last.push_back(out_last);
         end
         if (mode == 2 && out_valid && !out_ready) begin
            if (cyc == stall_at) held = out_data;
            else check({tag, " stall_data_stable"}, out_data, held);
            check({tag, " stall_in_ready"}, in_ready, 1'b0);
         end
         if (mode == 2 && stall_at < 0 && out_valid) stall_at = cyc + 1;
         @(posedge clk); #1;
         if (acc) idx++;
         in_valid = (idx < n);
         in_data  = (idx < n) ? src[idx] : 16'h0000;
         cyc++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      check({tag, " timeout"}, (cyc < 4000), 1'b1);
      repeat (3) @(negedge clk);
      check({tag, " out_count"}, got_data.size(), n);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " busy_end"}, busy, 1'b0);
      check({tag, " in_count"}, idx, n);
   endtask

   vec_t vecs[9];

   initial begin
      int acc_n;

      vecs[0] = '{1'b0, 4'd4, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF, 2,
                  '{16'h1234, 16'h5678, 16'h0, 16'h0}, '{16'h0123, 16'h4567, 16'h0, 16'h0}, 4'b0001, 4'b0010, 1'b0};
      vecs[1] = '{1'b1, 4'd4, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF, 2,
                  '{16'h1234, 16'h5678, 16'h0, 16'h0}, '{16'h2340, 16'h6781, 16'h0, 16'h0}, 4'b0001, 4'b0010, 1'b0};
      vecs[2] = '{1'b0, 4'd0, 6'd2, 10'd1, 16'h00FF, 16'hFF00, 2,
                  '{16'hFFFF, 16'hFFFF, 16'h0, 16'h0}, '{16'h00FF, 16'hFF00, 16'h0, 16'h0}, 4'b0001, 4'b0010, 1'b0};
      vecs[3] = '{1'b0, 4'd0, 6'd1, 10'd1, 16'h00FF, 16'hFF00, 1,
                  '{16'hFFFF, 16'h0, 16'h0, 16'h0}, '{16'h0000, 16'h0, 16'h0, 16'h0}, 4'b0001, 4'b0001, 1'b1};
      vecs[4] = '{1'b0, 4'd4, 6'd1, 10'd2, 16'hFFFF, 16'hFFFF, 2,
                  '{16'hFFFF, 16'hFFFF, 16'h0, 16'h0}, '{16'h0FFF, 16'h0FFF, 16'h0, 16'h0}, 4'b0011, 4'b0011, 1'b0};
      vecs[5] = '{1'b0, 4'd8, 6'd3, 10'd1, 16'h0FFF, 16'hFFF0, 3,
                  '{16'hAAAA, 16'h5555, 16'h1234, 16'h0}, '{16'h000A, 16'hAA55, 16'h5512, 16'h0}, 4'b0001, 4'b0100, 1'b0};
      vecs[6] = '{1'b1, 4'd15, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF, 2,
                  '{16'h0003, 16'hC000, 16'h0, 16'h0}, '{16'h8000, 16'h0001, 16'h0, 16'h0}, 4'b0001, 4'b0010, 1'b0};
      vecs[7] = '{1'b0, 4'd5, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF, 2,
                  '{16'h0000, 16'h0000, 16'h0, 16'h0}, '{16'h0000, 16'h0000, 16'h0, 16'h0}, 4'b0001, 4'b0010, 1'b1};
      vecs[8] = '{1'b0, 4'd4, 6'd2, 10'd2, 16'hFFFF, 16'hFFFF, 4,
                  '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{16'h0FFF, 16'hFFFF, 16'h0FFF, 16'hFFFF}, 4'b0101, 4'b1010, 1'b0};

      repeat (2) @(negedge clk);
      check("rst out_data", out_data, 16'h0000);
      check("rst out_valid", out_valid, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst zero", zero, 1'b0);
      check("rst in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int v = 0; v < 9; v++) begin
         src.delete();
         for (int j = 0; j < vecs[v].n; j++) src.push_back(vecs[v].din[j]);
         run_blit($sformatf("vec%0d", v), vecs[v].d, vecs[v].sh, vecs[v].hs, vecs[v].vs,
                  vecs[v].fm, vecs[v].lm, 0, 1'b0);
         for (int j = 0; j < vecs[v].n && j < got_data.size(); j++) begin
            check($sformatf("vec%0d data%0d", v, j), got_data[j], vecs[v].dout[j]);
            check($sformatf("vec%0d first%0d", v, j), got_first[j], vecs[v].fst[j]);
            check($sformatf("vec%0d last%0d", v, j), got_last[j], vecs[v].lst[j]);
         end
`ifdef BLITTER_ZERO_FLAG_EN
         check($sformatf("vec%0d zero", v), zero, vecs[v].zr);
`else
         check($sformatf("vec%0d zero_tied", v), zero, 1'b0);
`endif
      end

      // Mid-row backpressure.
      src.delete();
      for (int j = 0; j < 4; j++) src.push_back(16'h1111 * 16'(j + 1));
      run_blit("stall", 1'b0, 4'd0, 6'd4, 10'd1, 16'hFFFF, 16'hFFFF, 2, 1'b0);
      for (int j = 0; j < 4 && j < got_data.size(); j++)
         check($sformatf("stall data%0d", j), got_data[j], 16'h1111 * 16'(j + 1));

      // Maximum-width rows (hsize 0 = 64) under random sink readiness.
      src.delete();
      for (int j = 0; j < 192; j++) src.push_back(16'(j * 3 + 1));
      run_blit("rand", 1'b0, 4'd0, 6'd0, 10'd3, 16'hFFFF, 16'hFFFF, 1, 1'b0);
      for (int j = 0; j < 192 && j < got_data.size(); j++) begin
         check($sformatf("rand data%0d", j), got_data[j], 16'(j * 3 + 1));
         check($sformatf("rand first%0d", j), got_first[j], (j % 64) == 0);
         check($sformatf("rand last%0d", j), got_last[j], (j % 64) == 63);
      end

      // Reset asserted after three accepted words.
      done_cnt = 0;
      @(posedge clk); #1;
      desc = 1'b0; shift = 4'd2; hsize = 6'd8; vsize = 10'd1; fwm = 16'hFFFF; lwm = 16'hFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = 16'h0100; out_ready = 1'b1; acc_n = 0;
      for (int c = 0; c < 20 && acc_n < 3; c++) begin
         @(negedge clk);
         if (in_valid && in_ready) acc_n++;
         @(posedge clk); #1;
         in_data = in_data + 16'd1;
      end
      check("abort accepted", acc_n, 3);
      reset = 1'b1;
      #2;
      check("abort out_valid", out_valid, 1'b0);
      check("abort out_data", out_data, 16'h0000);
      check("abort busy", busy, 1'b0);
      check("abort in_ready", in_ready, 1'b0);
      check("abort first_last", {out_first, out_last}, 2'b00);
      check("abort zero", zero, 1'b0);
      repeat (2) @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("abort no_done", done_cnt, 0);
      check("abort idle_busy", busy, 1'b0);

      // Normal blit after abort, with an ignored start pulse during RUN.
      src.delete();
      src.push_back(16'h1234); src.push_back(16'h5678);
      run_blit("poke", 1'b0, 4'd4, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF, 0, 1'b1);
      if (got_data.size() == 2) begin
         check("poke data0", got_data[0], 16'h0123);
         check("poke data1", got_data[1], 16'h4567);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
